control_input_gate: RTL
=======================

Name: control_input_gate

Overview:
- Parametrised successor to the single-pointer mouse gate.
- Holds a 2-axis pointer position at a configurable home point until the game starts, then passes it through from the PS/2 front-end.
- Adds clamping to screen limits, a pause state, explicit restart from game-over, and optional per-sample slew limiting.
- Sits between the PS/2 mouse decoder and the game/render logic; its outputs are the only pointer coordinates the game core consumes.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- X_HOME, 0, x value held in IDLE and reloaded on restart/reset
- Y_HOME, 240, y value held in IDLE and reloaded on restart/reset
- X_MAX, 639, largest legal x; larger inputs are clamped
- Y_MAX, 479, largest legal y; larger inputs are clamped
- STEP_MAX, 8, maximum per-sample movement per axis (used only with SLEW_LIMIT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; begin play from IDLE
- pause  in  1  level; hold position while high during play
- gameover  in  1  level; end of play
- restart  in  1  level; return OVER to IDLE
- in_valid  in  1  x_in/y_in carry a new sample this cycle
- x_in  in  X_W  raw PS/2 x
- y_in  in  Y_W  raw PS/2 y
- x_out  out  X_W  gated pointer x
- y_out  out  Y_W  gated pointer y
- upd  out  1  one-cycle pulse: x_out/y_out were loaded from a sample this cycle
- state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset dominates every other input. On reset: state=IDLE, x_out=X_HOME, y_out=Y_HOME, upd=0.
- All outputs are registered.
- State transitions are evaluated on the current state; priority within a state is listed first-to-last:
  - IDLE: start -> RUN; otherwise stay. gameover and pause are ignored in IDLE.
  - RUN: gameover -> OVER; else pause -> PAUSE; else stay.
  - PAUSE: gameover -> OVER; else !pause -> RUN; else stay.
  - OVER: restart -> IDLE, and x_out/y_out reload X_HOME/Y_HOME in that same clock edge; otherwise stay.
- Sample acceptance:
  - A sample is accepted only when the current state is RUN and in_valid=1. This includes the cycle in which RUN exits to OVER or PAUSE.
  - The cycle in which IDLE->RUN fires does not accept a sample.
- Clamp:
  - xc = min(x_in, X_MAX); yc = min(y_in, Y_MAX), compared unsigned.
  - Coordinates never go negative; there is no wrap-around.
- Update:
  - An accepted sample loads x_out=xc and y_out=yc on the next edge, i.e. 1-cycle latency.
  - upd=1 in the cycle after acceptance, otherwise 0.
  - upd also fires when the loaded value equals the old value.
- In IDLE, PAUSE and OVER, x_out/y_out hold their value. IDLE always holds X_HOME/Y_HOME.
- Back-to-back in_valid in RUN: every cycle is accepted, with no bubbles.
- Reset in any state, mid-sample: the in-flight sample is discarded, upd=0, and home values are loaded.

Optional Feature:
- Macro: CONTROL_INPUT_SLEW_LIMIT_EN.
- Defined:
  - Each accepted sample moves each axis toward its clamped target by at most STEP_MAX.
  - If |target - current| <= STEP_MAX, the axis lands exactly on the target; otherwise it steps by STEP_MAX in the target's direction.
  - Differences are computed at X_W+1 / Y_W+1 bits signed, with no overflow.
  - Results remain within 0..MAX.
- Undefined: each accepted sample loads the clamped target directly, as in the Update rules above.

Test Plan:
- Reset, then hold start=0 and drive in_valid=1, x_in=100, y_in=50 for 10 cycles -> x_out=0, y_out=240, upd=0, state=0 throughout.
- start pulse, then sample (100,50) -> state=1 the cycle after start; x_out=100, y_out=50 and upd=1 one cycle after the sample.
- In RUN, sample (700,500) -> output (639,479). Sample (639,479) -> output unchanged, upd=1.
- In RUN, pause=1 with samples (10,10) -> state=2, output frozen. pause=0 -> state=1, next sample tracks. gameover together with pause in RUN -> state=3.
- In OVER, restart=1 -> state=0, output (0,240) next cycle. Reset asserted in RUN together with in_valid -> home output, upd=0.
- With CONTROL_INPUT_SLEW_LIMIT_EN and STEP_MAX=8, starting from (0,240), sample (100,200) -> output (8,232), then (16,224) on repeated samples. Target (3,238) from (0,240) -> output (3,238).

Source files
------------

// File: rtl/control_input_gate.sv
// Pointer gate between the PS/2 mouse decoder and the game core: holds home in IDLE, clamps and tracks in RUN.
// Latency: an accepted sample appears on x_out/y_out one clock later, with upd pulsing in that same cycle.
// No backpressure: every in_valid sample seen while RUN is accepted; samples seen in other states are dropped.
// Optional: define CONTROL_INPUT_SLEW_LIMIT_EN to limit per-sample movement to STEP_MAX per axis.
module control_input_gate #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int X_HOME   = 0,
  parameter int Y_HOME   = 240,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int STEP_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           pause,
  input  logic           gameover,
  input  logic           restart,
  input  logic           in_valid,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           upd,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Constants sized to the coordinate buses so every compare and add is width-matched.
  localparam logic [X_W-1:0] X_HOME_C = X_W'(X_HOME);
  localparam logic [Y_W-1:0] Y_HOME_C = Y_W'(Y_HOME);
  localparam logic [X_W-1:0] X_MAX_C  = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_C  = Y_W'(Y_MAX);

  // Step limits carry one extra bit so they compare directly against the signed differences.
  localparam logic signed [X_W:0] X_STEP = (X_W+1)'(STEP_MAX);
  localparam logic signed [Y_W:0] Y_STEP = (Y_W+1)'(STEP_MAX);

`ifdef CONTROL_INPUT_SLEW_LIMIT_EN
  localparam logic SLEW_ON = 1'b1;
`else
  localparam logic SLEW_ON = 1'b0;
`endif

  state_t         state_q;
  state_t         state_d;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           upd_q;

  logic           accept;
  logic           reload;
  logic [X_W-1:0] xc;
  logic [Y_W-1:0] yc;
  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic [X_W-1:0] x_slew;
  logic [Y_W-1:0] y_slew;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;

  // Next-state logic; first-listed condition wins within each state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (gameover)   state_d = OVER;
        else if (pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (gameover)    state_d = OVER;
        else if (!pause) state_d = RUN;
      end
      OVER: begin
        if (restart) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Acceptance looks only at the current state, so the exit cycle from RUN still takes a sample
  // and the IDLE->RUN cycle does not.
  always_comb begin
    accept = (state_q == RUN) && in_valid;
    reload = (state_q == OVER) && restart;
  end

  // Clamp raw coordinates to the visible screen; inputs are unsigned so only the top needs limiting.
  always_comb begin
    xc = (x_in > X_MAX_C) ? X_MAX_C : x_in;
    yc = (y_in > Y_MAX_C) ? Y_MAX_C : y_in;
  end

  // Slew-limited candidate: move toward the clamped target by at most the step on each axis.
  // The target is in range and we never step past it, so the result also stays in range.
  always_comb begin
    dx = $signed({1'b0, xc}) - $signed({1'b0, x_q});
    dy = $signed({1'b0, yc}) - $signed({1'b0, y_q});

    x_slew = xc;
    if (dx > X_STEP)
      x_slew = x_q + X_STEP[X_W-1:0];
    else if (dx < -X_STEP)
      x_slew = x_q - X_STEP[X_W-1:0];

    y_slew = yc;
    if (dy > Y_STEP)
      y_slew = y_q + Y_STEP[Y_W-1:0];
    else if (dy < -Y_STEP)
      y_slew = y_q - Y_STEP[Y_W-1:0];
  end

  // Select the value loaded by an accepted sample: slewed or direct clamped target.
  always_comb begin
    x_next = SLEW_ON ? x_slew : xc;
    y_next = SLEW_ON ? y_slew : yc;
  end

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Position and update-pulse registers; restart from OVER reloads home on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= X_HOME_C;
      y_q   <= Y_HOME_C;
      upd_q <= 1'b0;
    end else begin
      upd_q <= accept;
      if (reload) begin
        x_q <= X_HOME_C;
        y_q <= Y_HOME_C;
      end else if (accept) begin
        x_q <= x_next;
        y_q <= y_next;
      end
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign upd   = upd_q;
  assign state = state_q;

endmodule
